clkgen_prog: RTL and testbench
==============================

Name: clkgen_prog

Overview:
- Runtime reprogramming sequencer for the DCM_CLKGEN stage that sits directly downstream of the clock management tile. The tile's CLK0 output drives both this block and the DCM_CLKGEN PROGCLK pin.
- Accepts a multiply/divide request and serialises it onto PROGEN/PROGDATA.
- Waits for PROGDONE, then waits for LOCKED, then reports success or error.
- Lets host logic retune the hashing-core clock without a bitstream reload.

Parameters:
- DONE_TIMEOUT, 1024: max CLK cycles in WAIT_DONE before error.
- LOCK_TIMEOUT, 65535: max CLK cycles in WAIT_LOCK before error.
- CNT_WIDTH, 16: timeout counter width; must hold max(DONE_TIMEOUT, LOCK_TIMEOUT).

Ports:
- CLK  in  1  system clock; the same net drives DCM_CLKGEN PROGCLK.
- RESET  in  1  asynchronous, active-high reset.
- req_valid  in  1  request strobe.
- req_m  in  9  multiply value M; legal range 2..256.
- req_d  in  9  divide value D; legal range 1..256.
- req_ready  out  1  high only in IDLE.
- PROGEN  out  1  to DCM_CLKGEN.PROGEN.
- PROGDATA  out  1  to DCM_CLKGEN.PROGDATA.
- PROGDONE  in  1  from DCM_CLKGEN.PROGDONE.
- LOCKED  in  1  from DCM_CLKGEN.LOCKED.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  one-cycle pulse on reject or timeout.
- err_code  out  2  00 none, 01 illegal M/D, 10 PROGDONE timeout, 11 LOCKED timeout; held until the next accepted request.

Behaviour:
- Outputs under RESET: PROGEN=0, PROGDATA=0, req_ready=0, busy=0, done=0, error=0, err_code=00, state=IDLE. req_ready rises on the first clock edge after RESET deasserts.
- All outputs are registered.
- Handshake: a transfer occurs when req_valid && req_ready. On transfer:
  - latch m1=req_m-1 and d1=req_d-1, each 8 bits;
  - clear err_code;
  - req_ready drops the next cycle.
  - req_valid is ignored while busy.
- Validation happens in the cycle after transfer (state CHECK).
  - If M<2, M>256, D==0 or D>256: pulse error, set err_code=01, return to IDLE. PROGEN is never asserted.
  - Otherwise go to LOAD_D.
- LOAD_D lasts 10 cycles with PROGEN=1. PROGDATA sequence: 1, 0, then d1[0]..d1[7], LSB first.
- GAP1 lasts 1 cycle with PROGEN=0, PROGDATA=0.
- LOAD_M lasts 10 cycles with PROGEN=1. PROGDATA sequence: 1, 1, then m1[0]..m1[7], LSB first.
- GAP2 lasts 1 cycle with PROGEN=0.
- GO lasts 1 cycle with PROGEN=1, PROGDATA=0.
- WAIT_DONE: PROGEN=0; a counter starts at 0.
  - PROGDONE=1: go to WAIT_LOCK and reset the counter.
  - Counter reaches DONE_TIMEOUT-1 with no PROGDONE: pulse error, err_code=10, go to IDLE.
- WAIT_LOCK:
  - LOCKED=1: pulse done, go to IDLE.
  - Counter reaches LOCK_TIMEOUT-1 with no LOCKED: pulse error, err_code=11, go to IDLE.
- Simultaneous PROGDONE and timeout in the same cycle: PROGDONE wins. Same rule for LOCKED versus timeout.
- PROGDONE or LOCKED asserted in states other than WAIT_DONE/WAIT_LOCK: ignored.
- Latency from an accepted legal request to PROGEN first high: 2 cycles (CHECK, then LOAD_D).
- Minimum request-to-done time: 1+1+10+1+10+1+1+1+1 = 27 cycles, when PROGDONE and LOCKED are both already high on entry.
- RESET mid-sequence: PROGEN drops to 0 immediately (asynchronously). No done or error pulse. The DCM_CLKGEN is left to recover on the next full sequence.
- Bit counter: 4-bit, counts 0..9 and wraps back to 0 at each state change.
- Arithmetic: M-1 and D-1 are 9-bit subtractions truncated to 8 bits, computed only after the range check passes.

Decomposition:
- Shared package (clkgen_pkg) holds:
  - state enum: IDLE, CHECK, LOAD_D, GAP1, LOAD_M, GAP2, GO, WAIT_DONE, WAIT_LOCK;
  - constants CMD_LOAD_D=2'b01 and CMD_LOAD_M=2'b11, shifted bit0 first;
  - constant LOAD_LEN=10;
  - err_code localparams.
- One natural sub-module: clkgen_shifter. It is a 10-bit PISO that takes a 2-bit command plus an 8-bit value and drives PROGDATA plus a last-bit flag. The FSM and timeouts stay in clkgen_prog.

Test Plan:
- M=35, D=8, with PROGDONE 5 cycles after GO and LOCKED 20 cycles later.
  - Required PROGDATA: 1,0,1,1,1,0,0,0,0,0 during LOAD_D (d1=7); 1,1,0,1,0,0,0,1,0,0 during LOAD_M (m1=34).
  - Required: exactly one done pulse; err_code=00.
- M=1, D=8 → error pulse 2 cycles after transfer, err_code=01, PROGEN never high. Repeat with M=257 and with D=0 → same result.
- PROGDONE held 0 with DONE_TIMEOUT=16 → error exactly 16 cycles after entering WAIT_DONE, err_code=10, req_ready back high next cycle.
- PROGDONE=1 but LOCKED=0 with LOCK_TIMEOUT=32 → error, err_code=11. Then a new legal request clears err_code at transfer.
- Assert RESET during bit 4 of LOAD_M → PROGEN=0 within the same cycle, busy=0, no pulses. After release, a full legal sequence completes normally.
- req_valid held high throughout a sequence → only one transfer. A second transfer occurs the cycle after return to IDLE with req_ready=1.

Source files
------------

// File: rtl/clkgen_pkg.sv
// Shared types and constants for the DCM_CLKGEN reprogramming sequencer.
package clkgen_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CHECK,
    LOAD_D,
    GAP1,
    LOAD_M,
    GAP2,
    GO,
    WAIT_DONE,
    WAIT_LOCK
  } state_t;

  typedef struct packed {
    logic [8:0] m;
    logic [8:0] d;
  } req_t;

  // Command prefixes, shifted out bit0 first.
  localparam logic [1:0] CMD_LOAD_D = 2'b01;
  localparam logic [1:0] CMD_LOAD_M = 2'b11;

  localparam int LOAD_LEN = 10;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_RANGE   = 2'b01;
  localparam logic [1:0] ERR_DONE_TO = 2'b10;
  localparam logic [1:0] ERR_LOCK_TO = 2'b11;

  function automatic logic md_legal(
    input logic [8:0] m,
    input logic [8:0] d
  );
    return (m >= 9'd2) && (m <= 9'd256) &&
           (d != 9'd0) && (d <= 9'd256);
  endfunction

endpackage

// File: rtl/clkgen_prog_if.sv
// Request handshake between host logic and the clkgen sequencer.
interface clkgen_prog_if;

  logic       req_valid;
  logic [8:0] req_m;
  logic [8:0] req_d;
  logic       req_ready;

  modport master (
    output req_valid,
    output req_m,
    output req_d,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_m,
    input  req_d,
    output req_ready
  );

endinterface

// File: rtl/clkgen_shifter.sv
// 10-bit PISO for DCM_CLKGEN load words: 2-bit command then 8-bit value.
module clkgen_shifter
  import clkgen_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       shift,
  input  logic       clear,
  input  logic [1:0] cmd,
  input  logic [7:0] val,
  output logic       data,
  output logic       last
);

  logic [LOAD_LEN-1:0] sh;
  logic [3:0]          bit_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh      <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      sh      <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      sh      <= {val, cmd};
      bit_cnt <= '0;
    end else if (shift) begin
      sh      <= {1'b0, sh[LOAD_LEN-1:1]};
      bit_cnt <= last ? 4'd0 : bit_cnt + 4'd1;
    end
  end

  // sh[0] is a flop, so PROGDATA stays registered.
  assign data = sh[0];
  assign last = (bit_cnt == 4'(LOAD_LEN - 1));

endmodule

// File: rtl/clkgen_prog.sv
// DCM_CLKGEN runtime M/D reprogramming sequencer with PROGDONE/LOCKED timeouts.
module clkgen_prog
  import clkgen_pkg::*;
#(
  parameter int DONE_TIMEOUT = 1024,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  clkgen_prog_if.slave        bus,
  output logic                PROGEN,
  output logic                PROGDATA,
  input  logic                PROGDONE,
  input  logic                LOCKED,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [1:0]          err_code
);

  localparam logic [CNT_WIDTH-1:0] DONE_LAST =
    CNT_WIDTH'(DONE_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] LOCK_LAST =
    CNT_WIDTH'(LOCK_TIMEOUT - 1);

  state_t               state;
  req_t                 req_q;
  logic [CNT_WIDTH-1:0] cnt;

  logic       legal;
  logic       in_load;
  logic       sh_load;
  logic       sh_shift;
  logic       sh_clear;
  logic       sh_last;
  logic [1:0] sh_cmd;
  logic [7:0] sh_val;

  assign legal   = md_legal(req_q.m, req_q.d);
  assign in_load = (state == LOAD_D) || (state == LOAD_M);

  assign sh_load  = ((state == CHECK) && legal) ||
                    (state == GAP1);
  assign sh_shift = in_load && !sh_last;
  assign sh_clear = in_load && sh_last;
  assign sh_cmd   = (state == GAP1) ? CMD_LOAD_M : CMD_LOAD_D;
  // Only consumed on a load, i.e. after the range check passed.
  assign sh_val   = (state == GAP1) ? 8'(req_q.m - 9'd1)
                                    : 8'(req_q.d - 9'd1);

  clkgen_shifter u_shifter (
    .clk   (CLK),
    .rst   (RESET),
    .load  (sh_load),
    .shift (sh_shift),
    .clear (sh_clear),
    .cmd   (sh_cmd),
    .val   (sh_val),
    .data  (PROGDATA),
    .last  (sh_last)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= IDLE;
      req_q         <= '0;
      cnt           <= '0;
      bus.req_ready <= 1'b0;
      busy          <= 1'b0;
      PROGEN        <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_code      <= ERR_NONE;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      unique case (state)
        IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            req_q         <= '{m: bus.req_m, d: bus.req_d};
            err_code      <= ERR_NONE;
            bus.req_ready <= 1'b0;
            busy          <= 1'b1;
            state         <= CHECK;
          end
        end
        CHECK: begin
          if (!legal) begin
            error         <= 1'b1;
            err_code      <= ERR_RANGE;
            busy          <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end else begin
            PROGEN <= 1'b1;
            state  <= LOAD_D;
          end
        end
        LOAD_D: begin
          if (sh_last) begin
            PROGEN <= 1'b0;
            state  <= GAP1;
          end
        end
        GAP1: begin
          PROGEN <= 1'b1;
          state  <= LOAD_M;
        end
        LOAD_M: begin
          if (sh_last) begin
            PROGEN <= 1'b0;
            state  <= GAP2;
          end
        end
        GAP2: begin
          PROGEN <= 1'b1;
          state  <= GO;
        end
        GO: begin
          PROGEN <= 1'b0;
          cnt    <= '0;
          state  <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (PROGDONE) begin
            cnt   <= '0;
            state <= WAIT_LOCK;
          end else if (cnt == DONE_LAST) begin
            error         <= 1'b1;
            err_code      <= ERR_DONE_TO;
            busy          <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (LOCKED) begin
            done          <= 1'b1;
            busy          <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end else if (cnt == LOCK_LAST) begin
            error         <= 1'b1;
            err_code      <= ERR_LOCK_TO;
            busy          <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy          <= 1'b0;
          PROGEN        <= 1'b0;
          bus.req_ready <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clkgen_prog.sv
// Directed vector bench for clkgen_prog.
module tb_clkgen_prog;
  import clkgen_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       PROGEN;
  logic       PROGDATA;
  logic       PROGDONE = 1'b0;
  logic       LOCKED = 1'b0;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] err_code;

  clkgen_prog_if bus ();

  clkgen_prog #(
    .DONE_TIMEOUT (16),
    .LOCK_TIMEOUT (32),
    .CNT_WIDTH    (16)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .bus      (bus),
    .PROGEN   (PROGEN),
    .PROGDATA (PROGDATA),
    .PROGDONE (PROGDONE),
    .LOCKED   (LOCKED),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_code (err_code)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string      name;
    logic [8:0] m;
    logic [8:0] d;
    int         done_dly;
    int         lock_dly;
    bit         pre;
    int         exp_end;
    int         exp_done;
    logic [1:0] exp_code;
    int         exp_pen;
    logic [9:0] exp_d;
    logic [9:0] exp_m;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  // Issues one request and follows it until req_ready returns.
  // n counts samples taken 2ns after each edge; n=0 follows the transfer edge.
  task automatic run_req(
    input  logic [8:0] m,
    input  logic [8:0] d,
    input  int         done_dly,
    input  int         lock_dly,
    input  bit         pre,
    input  bit         hold,
    output int         end_n,
    output int         n_done,
    output int         n_err,
    output int         pen_cnt,
    output int         first_pen,
    output logic [1:0] code0,
    output logic [1:0] code_end,
    output logic [9:0] d_bits,
    output logic [9:0] m_bits
  );
    int g;
    int pd_at;
    int n;
    bit fin;
    g = -1; pd_at = -1; n = 0; fin = 1'b0;
    end_n = -1; n_done = 0; n_err = 0;
    pen_cnt = 0; first_pen = -1;
    code0 = 2'bxx; code_end = 2'bxx;
    d_bits = '0; m_bits = '0;
    PROGDONE = pre;
    LOCKED   = pre;
    bus.req_valid = 1'b1;
    bus.req_m     = m;
    bus.req_d     = d;
    step();
    if (!hold) bus.req_valid = 1'b0;
    while (!fin && n < 200) begin
      if (n == 0) code0 = err_code;
      if (PROGEN) begin
        if (first_pen < 0) first_pen = n;
        if (pen_cnt < 10) d_bits[pen_cnt] = PROGDATA;
        else if (pen_cnt < 20) m_bits[pen_cnt-10] = PROGDATA;
        pen_cnt++;
        if (pen_cnt == 21) g = n;
      end
      n_done += int'(done);
      n_err  += int'(error);
      if (bus.req_ready) begin
        fin = 1'b1;
        end_n = n;
        code_end = err_code;
      end else begin
        if (!pre && done_dly >= 0 && g >= 0 &&
            n >= g + done_dly && pd_at < 0) begin
          PROGDONE = 1'b1;
          pd_at = n;
        end
        if (!pre && lock_dly >= 0 && pd_at >= 0 &&
            n >= pd_at + lock_dly)
          LOCKED = 1'b1;
        step();
        n++;
      end
    end
    if (!fin) begin
      n_vec++;
      n_bad++;
      $display("FAIL run_bound: got busy after %0d cycles want idle", n);
    end
    if (!hold) begin
      PROGDONE = 1'b0;
      LOCKED   = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         end_n, n_done, n_err, pen_cnt, first_pen, cnt, pulses;
    logic [1:0] code0, code_end;
    logic [9:0] d_bits, m_bits;

    vecs[0] = '{"m35_d8",   9'd35,  9'd8,   5, 20, 1'b0, 49, 1,
                ERR_NONE,    21, 10'b0000011101, 10'b0010001011};
    vecs[1] = '{"m1",       9'd1,   9'd8,  -1, -1, 1'b0,  1, 0,
                ERR_RANGE,    0, 10'b0, 10'b0};
    vecs[2] = '{"m257",     9'd257, 9'd8,  -1, -1, 1'b0,  1, 0,
                ERR_RANGE,    0, 10'b0, 10'b0};
    vecs[3] = '{"d0",       9'd35,  9'd0,  -1, -1, 1'b0,  1, 0,
                ERR_RANGE,    0, 10'b0, 10'b0};
    vecs[4] = '{"d257",     9'd35,  9'd257,-1, -1, 1'b0,  1, 0,
                ERR_RANGE,    0, 10'b0, 10'b0};
    vecs[5] = '{"m2_d1",    9'd2,   9'd1,   0,  0, 1'b0, 26, 1,
                ERR_NONE,    21, 10'b0000000001, 10'b0000000111};
    vecs[6] = '{"m256_d256",9'd256, 9'd256, 0,  0, 1'b0, 26, 1,
                ERR_NONE,    21, 10'b1111111101, 10'b1111111111};
    vecs[7] = '{"done_to",  9'd35,  9'd8,  -1, -1, 1'b0, 40, 0,
                ERR_DONE_TO, 21, 10'b0000011101, 10'b0010001011};
    vecs[8] = '{"lock_to",  9'd35,  9'd8,   0, -1, 1'b0, 57, 0,
                ERR_LOCK_TO, 21, 10'b0000011101, 10'b0010001011};
    vecs[9] = '{"pre_min",  9'd35,  9'd8,   0,  0, 1'b1, 26, 1,
                ERR_NONE,    21, 10'b0000011101, 10'b0010001011};

    bus.req_valid = 1'b0;
    bus.req_m     = '0;
    bus.req_d     = '0;

    #12;
    check("rst_progen",   32'(PROGEN),        0);
    check("rst_progdata", 32'(PROGDATA),      0);
    check("rst_ready",    32'(bus.req_ready), 0);
    check("rst_busy",     32'(busy),          0);
    check("rst_pulses",   32'({done, error}), 0);
    check("rst_code",     32'(err_code),      0);
    @(negedge CLK);
    RESET = 1'b0;
    step();
    check("ready_after_rst", 32'(bus.req_ready), 1);

    for (int i = 0; i < 10; i++) begin
      run_req(vecs[i].m, vecs[i].d, vecs[i].done_dly,
              vecs[i].lock_dly, vecs[i].pre, 1'b0,
              end_n, n_done, n_err, pen_cnt, first_pen,
              code0, code_end, d_bits, m_bits);
      check({vecs[i].name, "_end"},   32'(end_n), 32'(vecs[i].exp_end));
      check({vecs[i].name, "_done"},  32'(n_done), 32'(vecs[i].exp_done));
      check({vecs[i].name, "_err"},   32'(n_err),
            32'(1 - vecs[i].exp_done));
      check({vecs[i].name, "_code"},  32'(code_end),
            32'(vecs[i].exp_code));
      check({vecs[i].name, "_clr"},   32'(code0), 0);
      check({vecs[i].name, "_pen"},   32'(pen_cnt), 32'(vecs[i].exp_pen));
      check({vecs[i].name, "_first"}, 32'(first_pen),
            (vecs[i].exp_pen > 0) ? 32'd1 : 32'hFFFF_FFFF);
      check({vecs[i].name, "_dbits"}, 32'(d_bits), 32'(vecs[i].exp_d));
      check({vecs[i].name, "_mbits"}, 32'(m_bits), 32'(vecs[i].exp_m));
    end

    // Reset during bit 4 of LOAD_M.
    bus.req_valid = 1'b1;
    bus.req_m = 9'd35;
    bus.req_d = 9'd8;
    step();
    bus.req_valid = 1'b0;
    repeat (16) step();
    check("mid_progen_pre", 32'(PROGEN), 1);
    #1 RESET = 1'b1;
    #1;
    check("mid_progen", 32'(PROGEN), 0);
    check("mid_busy",   32'(busy),   0);
    check("mid_ready",  32'(bus.req_ready), 0);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      pulses += int'(done) + int'(error);
    end
    RESET = 1'b0;
    step();
    pulses += int'(done) + int'(error);
    check("mid_pulses", 32'(pulses), 0);
    check("mid_ready_back", 32'(bus.req_ready), 1);
    run_req(9'd35, 9'd8, 5, 20, 1'b0, 1'b0,
            end_n, n_done, n_err, pen_cnt, first_pen,
            code0, code_end, d_bits, m_bits);
    check("post_rst_end",   32'(end_n), 49);
    check("post_rst_done",  32'(n_done), 1);
    check("post_rst_dbits", 32'(d_bits), 32'(10'b0000011101));
    check("post_rst_mbits", 32'(m_bits), 32'(10'b0010001011));

    // req_valid held high: one transfer per sequence.
    run_req(9'd35, 9'd8, 0, 0, 1'b1, 1'b1,
            end_n, n_done, n_err, pen_cnt, first_pen,
            code0, code_end, d_bits, m_bits);
    check("hold_end",  32'(end_n), 26);
    check("hold_done", 32'(n_done), 1);
    check("hold_pen",  32'(pen_cnt), 21);
    step();
    check("hold_second_busy",  32'(busy), 1);
    check("hold_second_ready", 32'(bus.req_ready), 0);
    bus.req_valid = 1'b0;
    cnt = 0;
    n_done = 0;
    while (!bus.req_ready && cnt < 60) begin
      step();
      cnt++;
      n_done += int'(done);
    end
    check("hold_second_done", 32'(n_done), 1);
    check("hold_second_len",  32'(cnt), 26);
    PROGDONE = 1'b0;
    LOCKED   = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
